// File: rtl/fpu_norm_pkg.sv
// Shared widths, stage payload and exponent-adjust helper
// for the FPU leading-one normalization shifter.
package fpu_norm_pkg;

  localparam int WIDTH     = 106;
  localparam int WIDTH_LOG = 7;
  localparam int EXP_W     = 12;
  localparam int SPLIT     = 4;

  localparam logic [WIDTH_LOG-1:0] MSB_MAX =
    WIDTH_LOG'(WIDTH - 1);

  typedef struct packed {
    logic [WIDTH-1:0] mant;
    logic [SPLIT-1:0] fine;
    logic [EXP_W-1:0] expo;
    logic             zero;
    logic             underflow;
  } norm_pay_t;

  typedef struct packed {
    logic [WIDTH_LOG-1:0] eff;
    logic [EXP_W-1:0]     expo;
    logic                 underflow;
  } norm_adj_t;

  function automatic norm_adj_t norm_adjust(
    input logic [WIDTH_LOG-1:0] msb,
    input logic [EXP_W-1:0]     expo,
    input logic                 zero
  );
    norm_adj_t            r;
    logic [WIDTH_LOG-1:0] m;
    logic [WIDTH_LOG-1:0] sh;
    r  = '0;
    m  = (msb > MSB_MAX) ? MSB_MAX : msb;
    sh = MSB_MAX - m;
    if (zero) begin
      r = '0;
    end else if (EXP_W'(sh) <= expo) begin
      r.eff  = sh;
      r.expo = expo - EXP_W'(sh);
    end else begin
      // exponent runs out first: stop at denormal
      r.eff       = expo[WIDTH_LOG-1:0];
      r.underflow = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fpu_norm_if.sv
// Valid/ready bundle for the normalization shifter:
// producer beat in, normalized result out.
interface fpu_norm_if;
  import fpu_norm_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_value;
  logic [WIDTH_LOG-1:0] in_msb;
  logic                 in_zero;
  logic [EXP_W-1:0]     in_exp;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_mant;
  logic [EXP_W-1:0]     out_exp;
  logic                 out_zero;
  logic                 out_underflow;

  modport slave (
    input  in_valid, in_value, in_msb,
    input  in_zero, in_exp, out_ready,
    output in_ready, out_valid, out_mant,
    output out_exp, out_zero, out_underflow
  );

  modport master (
    output in_valid, in_value, in_msb,
    output in_zero, in_exp, out_ready,
    input  in_ready, out_valid, out_mant,
    input  out_exp, out_zero, out_underflow
  );

endinterface

// File: rtl/fpu_norm_stage.sv
// One valid/ready pipeline register that left-shifts the
// mantissa by the shift bits selected by MASK.
module fpu_norm_stage
  import fpu_norm_pkg::*;
#(
  parameter logic [WIDTH_LOG-1:0] MASK = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  norm_pay_t            in_data,
  input  logic [WIDTH_LOG-1:0] shift,
  output logic                 out_valid,
  input  logic                 out_ready,
  output norm_pay_t            out_data
);

  logic                 load;
  logic [WIDTH_LOG-1:0] amt;
  norm_pay_t            nxt;

  assign load     = !out_valid || out_ready;
  assign in_ready = load;
  assign amt      = shift & MASK;

  always_comb begin
    nxt      = in_data;
    nxt.mant = in_data.mant << amt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= nxt;
    end
  end

endmodule

// File: rtl/fpu_norm_shifter.sv
// Two-stage left normalizer: coarse shift, then fine shift,
// with exponent clamped to denormal on underflow.
module fpu_norm_shifter
  import fpu_norm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  fpu_norm_if.slave  bus
);

  localparam logic [WIDTH_LOG-1:0] COARSE =
    WIDTH_LOG'((1 << WIDTH_LOG) - (1 << SPLIT));
  localparam logic [WIDTH_LOG-1:0] FINE =
    WIDTH_LOG'((1 << SPLIT) - 1);

  norm_adj_t adj;
  norm_pay_t s0;
  norm_pay_t s1;
  norm_pay_t s2;
  logic      s1_v;
  logic      s2_rdy;
  logic      s2_v;

  assign adj = norm_adjust(bus.in_msb, bus.in_exp,
                           bus.in_zero);

  always_comb begin
    s0           = '0;
    s0.mant      = bus.in_zero ? '0 : bus.in_value;
    s0.fine      = adj.eff[SPLIT-1:0];
    s0.expo      = adj.expo;
    s0.zero      = bus.in_zero;
    s0.underflow = adj.underflow;
  end

  fpu_norm_stage #(.MASK(COARSE)) u_coarse (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (s0),
    .shift     (adj.eff),
    .out_valid (s1_v),
    .out_ready (s2_rdy),
    .out_data  (s1)
  );

  fpu_norm_stage #(.MASK(FINE)) u_fine (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_v),
    .in_ready  (s2_rdy),
    .in_data   (s1),
    .shift     ({{(WIDTH_LOG-SPLIT){1'b0}}, s1.fine}),
    .out_valid (s2_v),
    .out_ready (bus.out_ready),
    .out_data  (s2)
  );

  assign bus.out_valid     = s2_v;
  assign bus.out_mant      = s2.mant;
  assign bus.out_exp       = s2.expo;
  assign bus.out_zero      = s2.zero;
  assign bus.out_underflow = s2.underflow;

endmodule

// File: tb/tb_fpu_norm_shifter.sv
// Directed-vector bench for fpu_norm_shifter.
module tb_fpu_norm_shifter;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  fpu_norm_if bus ();

  fpu_norm_shifter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [105:0] ref_mant(
    input logic [105:0] v, input int msb, input int e);
    int m;
    int sh;
    m  = (msb > 105) ? 105 : msb;
    sh = 105 - m;
    if (sh <= e) return v << sh;
    return v << e;
  endfunction

  function automatic logic [11:0] ref_exp(
    input int msb, input int e);
    int m;
    int sh;
    m  = (msb > 105) ? 105 : msb;
    sh = 105 - m;
    if (sh <= e) return 12'(e - sh);
    return 12'd0;
  endfunction

  function automatic logic ref_uf(input int msb, input int e);
    int m;
    m = (msb > 105) ? 105 : msb;
    return (105 - m) > e;
  endfunction

  task automatic set_in(input logic [105:0] v,
    input logic [6:0] msb, input logic z,
    input logic [11:0] e);
    bus.in_valid = 1'b1;
    bus.in_value = v;
    bus.in_msb   = msb;
    bus.in_zero  = z;
    bus.in_exp   = e;
  endtask

  // one beat in with out_ready high; returns one edge
  // before the result is due
  task automatic drive_beat(input logic [105:0] v,
    input logic [6:0] msb, input logic z,
    input logic [11:0] e);
    bus.out_ready = 1'b1;
    set_in(v, msb, z, e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_mant !== '0 ||
        bus.out_exp !== '0 || bus.out_zero !== 1'b0 ||
        bus.out_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: v=%b m=%h e=%0d z=%b u=%b want all 0",
        bus.out_valid, bus.out_mant, bus.out_exp,
        bus.out_zero, bus.out_underflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_nominal;
    logic [105:0] v;
    v = 106'd1 << 50;
    drive_beat(v, 7'd50, 1'b0, 12'd1000);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL nom_latency1: out_valid=%b want 0", bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 ||
        bus.out_mant !== (106'd1 << 105) ||
        bus.out_exp !== 12'd945 || bus.out_zero !== 1'b0 ||
        bus.out_underflow !== 1'b0) begin
      errors++;
      $display("FAIL nominal: v=%b m=%h e=%0d z=%b u=%b want 1 %h 945 0 0",
        bus.out_valid, bus.out_mant, bus.out_exp, bus.out_zero,
        bus.out_underflow, 106'd1 << 105);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_underflow;
    logic [105:0] v;
    v = 106'd1 << 50;
    drive_beat(v, 7'd50, 1'b0, 12'd10);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 ||
        bus.out_mant !== (106'd1 << 60) ||
        bus.out_exp !== 12'd0 || bus.out_underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow: v=%b m=%h e=%0d u=%b want 1 %h 0 1",
        bus.out_valid, bus.out_mant, bus.out_exp,
        bus.out_underflow, 106'd1 << 60);
    end
    @(posedge clk); #1;
    v = 106'd1 << 95;
    drive_beat(v, 7'd95, 1'b0, 12'd10);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 ||
        bus.out_mant !== (106'd1 << 105) ||
        bus.out_exp !== 12'd0 || bus.out_underflow !== 1'b0) begin
      errors++;
      $display("FAIL sh_eq_exp: v=%b m=%h e=%0d u=%b want 1 %h 0 0",
        bus.out_valid, bus.out_mant, bus.out_exp,
        bus.out_underflow, 106'd1 << 105);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_noshift;
    logic [105:0] v;
    drive_beat(106'd123, 7'd6, 1'b1, 12'd500);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_mant !== '0 ||
        bus.out_exp !== 12'd0 || bus.out_zero !== 1'b1 ||
        bus.out_underflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_in: v=%b m=%h e=%0d z=%b u=%b want 1 0 0 1 0",
        bus.out_valid, bus.out_mant, bus.out_exp,
        bus.out_zero, bus.out_underflow);
    end
    @(posedge clk); #1;
    v = 106'd1 << 105;
    drive_beat(v, 7'd105, 1'b0, 12'd77);
    @(posedge clk); #1;
    checks++;
    if (bus.out_mant !== v || bus.out_exp !== 12'd77 ||
        bus.out_underflow !== 1'b0 || bus.out_zero !== 1'b0) begin
      errors++;
      $display("FAIL no_shift: m=%h e=%0d u=%b want %h 77 0",
        bus.out_mant, bus.out_exp, bus.out_underflow, v);
    end
    @(posedge clk); #1;
    v = (106'd1 << 105) | 106'd5;
    drive_beat(v, 7'd127, 1'b0, 12'd33);
    @(posedge clk); #1;
    checks++;
    if (bus.out_mant !== v || bus.out_exp !== 12'd33 ||
        bus.out_underflow !== 1'b0) begin
      errors++;
      $display("FAIL msb_clamp: m=%h e=%0d u=%b want %h 33 0",
        bus.out_mant, bus.out_exp, bus.out_underflow, v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [105:0] ma;
    logic [105:0] mb;
    logic [105:0] mc;
    ma = 106'd1 << 105;
    mb = (106'd1 << 105) | (106'd1 << 85);
    mc = 106'd3 << 50;
    bus.out_ready = 1'b0;
    set_in(106'd1 << 50, 7'd50, 1'b0, 12'd1000);
    @(posedge clk); #1;
    set_in((106'd1 << 20) | 106'd1, 7'd20, 1'b0, 12'd300);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept_b: in_ready=%b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    set_in(106'd3, 7'd1, 1'b0, 12'd50);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
        bus.out_mant !== ma) begin
      errors++;
      $display("FAIL bp_stall: rdy=%b v=%b m=%h want 0 1 %h",
        bus.in_ready, bus.out_valid, bus.out_mant, ma);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_mant !== ma || bus.out_exp !== 12'd945 ||
        bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: m=%h e=%0d rdy=%b want %h 945 0",
        bus.out_mant, bus.out_exp, bus.in_ready, ma);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_mant !== mb ||
        bus.out_exp !== 12'd215) begin
      errors++;
      $display("FAIL bp_b: v=%b m=%h e=%0d want 1 %h 215",
        bus.out_valid, bus.out_mant, bus.out_exp, mb);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_mant !== mc ||
        bus.out_exp !== 12'd0 || bus.out_underflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_c: v=%b m=%h e=%0d u=%b want 1 %h 0 1",
        bus.out_valid, bus.out_mant, bus.out_exp,
        bus.out_underflow, mc);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_throughput;
    logic [105:0] tv [8];
    logic [6:0]   tm [8];
    logic [11:0]  te [8];
    logic [127:0] r;
    for (int i = 0; i < 8; i++) begin
      tm[i] = 7'($urandom_range(0, 105));
      te[i] = 12'($urandom_range(0, 200));
      r     = {$urandom, $urandom, $urandom, $urandom};
      tv[i] = r[105:0] & ((106'd1 << tm[i]) - 106'd1);
      tv[i] = tv[i] | (106'd1 << tm[i]);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        set_in(tv[c], tm[c], 1'b0, te[c]);
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL tp_ready[%0d]: got %b want 1", c, bus.in_ready);
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL tp_early: out_valid=%b want 0", bus.out_valid);
        end
      end else if (c <= 8) begin
        checks++;
        if (bus.out_valid !== 1'b1 ||
            bus.out_mant !== ref_mant(tv[c-1], tm[c-1], te[c-1]) ||
            bus.out_exp !== ref_exp(tm[c-1], te[c-1]) ||
            bus.out_underflow !== ref_uf(tm[c-1], te[c-1])) begin
          errors++;
          $display("FAIL tp_beat[%0d]: v=%b m=%h e=%0d u=%b want %h %0d %b",
            c - 1, bus.out_valid, bus.out_mant, bus.out_exp,
            bus.out_underflow,
            ref_mant(tv[c-1], tm[c-1], te[c-1]),
            ref_exp(tm[c-1], te[c-1]), ref_uf(tm[c-1], te[c-1]));
        end
      end
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL tp_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_midflight;
    int stale;
    bus.out_ready = 1'b0;
    set_in(106'd1 << 10, 7'd10, 1'b0, 12'd900);
    @(posedge clk); #1;
    set_in(106'd1 << 11, 7'd11, 1'b0, 12'd900);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_full: v=%b rdy=%b want 1 0",
        bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: out_valid=%b want 0", bus.out_valid);
    end
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
    end
    stale = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL rst_stale: %0d valid cycles want 0", stale);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.in_msb    = '0;
    bus.in_zero   = 1'b0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b0;
    test_reset;
    test_nominal;
    test_underflow;
    test_zero_noshift;
    test_backpressure;
    test_throughput;
    test_reset_midflight;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
